dmem_ctrl: RTL and testbench

Data-memory controller that sits directly downstream of the `mips` core's memory stage. It consumes each load/store request (address, store data, `MemWr`/`MemRead` codes) through a valid/ready handshake. It owns a word-organised data RAM with a programmable access latency, generates byte lanes, and returns sign- or zero-extended load data. It also flags misaligned accesses instead of performing them.

---
 rtl/dmem_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory controller behind the core's memory stage.
// Accepts one load/store at a time over valid/ready, waits LATENCY cycles,
// performs a byte-lane RAM access and returns extended load data.
// Misaligned requests are answered immediately with misalign=1 and no RAM access.
module dmem_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  mem_wr,
  input  logic [2:0]  mem_read,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [3:0] LAT_INIT = 4'(LATENCY);
  localparam int         AW       = ADDR_WIDTH + 2;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [1:0]      wr_q, wr_d;
  logic [2:0]      rd_q, rd_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            misalign_q, misalign_d;

  logic [31:0]     ram_q [2**ADDR_WIDTH];

  logic            is_st_s, is_ld_s, op_valid_s, mis_s;
  logic            ram_we_s;
  logic [3:0]      be_s;
  logic [31:0]     wlane_s;
  logic [31:0]     word_s, load_s;
  logic [15:0]     half_s;
  logic [7:0]      byte_s;
  logic [ADDR_WIDTH-1:0] idx_s;
  logic            unused_addr_s;

  // Upper address bits only alias the RAM, so they are deliberately dropped.
  assign unused_addr_s = ^addr[31:AW];

  assign idx_s  = addr_q[AW-1:2];
  assign word_s = ram_q[idx_s];

  // Decode the incoming request: op presence and alignment by access size.
  always_comb begin
    is_st_s    = (mem_wr != 2'b00);
    is_ld_s    = (mem_read >= 3'd1) && (mem_read <= 3'd5);
    op_valid_s = is_st_s || is_ld_s;
    mis_s      = 1'b0;
    if (is_st_s) begin
      case (mem_wr)
        2'b01:   mis_s = (addr[1:0] != 2'b00);
        2'b10:   mis_s = addr[0];
        default: mis_s = 1'b0;
      endcase
    end else begin
      case (mem_read)
        3'd1:       mis_s = (addr[1:0] != 2'b00);
        3'd2, 3'd3: mis_s = addr[0];
        default:    mis_s = 1'b0;
      endcase
    end
  end

  // Byte enables and lane-replicated store data for the latched store.
  always_comb begin
    be_s    = 4'b0000;
    wlane_s = wdata_q;
    case (wr_q)
      2'b01: begin
        be_s    = 4'b1111;
        wlane_s = wdata_q;
      end
      2'b10: begin
        be_s    = addr_q[1] ? 4'b1100 : 4'b0011;
        wlane_s = {2{wdata_q[15:0]}};
      end
      2'b11: begin
        be_s    = 4'b0001 << addr_q[1:0];
        wlane_s = {4{wdata_q[7:0]}};
      end
      default: begin
        be_s    = 4'b0000;
        wlane_s = wdata_q;
      end
    endcase
  end

  // Lane selection and sign/zero extension of the addressed RAM word.
  always_comb begin
    half_s = addr_q[1] ? word_s[31:16] : word_s[15:0];
    byte_s = 8'(word_s >> {addr_q[1:0], 3'b000});
    case (rd_q)
      3'd1:    load_s = word_s;
      3'd2:    load_s = {{16{half_s[15]}}, half_s};
      3'd3:    load_s = {16'h0000, half_s};
      3'd4:    load_s = {{24{byte_s[7]}}, byte_s};
      3'd5:    load_s = {24'h000000, byte_s};
      default: load_s = 32'h0000_0000;
    endcase
  end

  // Next-state logic: accept in IDLE, count down in WAIT, pulse in RESP.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    rdata_d    = rdata_q;
    misalign_d = 1'b0;
    ram_we_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && op_valid_s) begin
          addr_d  = addr[AW-1:0];
          wdata_d = wdata;
          wr_d    = mem_wr;
          // A store takes precedence; the load code is discarded.
          rd_d    = is_st_s ? 3'd0 : mem_read;
          if (mis_s) begin
            state_d    = ST_RESP;
            misalign_d = 1'b1;
            rdata_d    = 32'h0000_0000;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = LAT_INIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
          if (wr_q != 2'b00) begin
            ram_we_s = 1'b1;
            rdata_d  = 32'h0000_0000;
          end else begin
            rdata_d  = load_s;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= '0;
      wdata_q    <= 32'h0000_0000;
      wr_q       <= 2'b00;
      rd_q       <= 3'd0;
      rdata_q    <= 32'h0000_0000;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
    end
  end

  // RAM byte-lane write; contents survive reset but reset blocks a pending write.
  always_ff @(posedge clk) begin
    if (!rst && ram_we_s) begin
      for (int k = 0; k < 4; k++) begin
        if (be_s[k]) begin
          ram_q[idx_s][8*k +: 8] <= wlane_s[8*k +: 8];
        end
      end
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign busy       = (state_q != ST_IDLE);
  assign rdata      = rdata_q;
  assign misalign   = misalign_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl (LATENCY=2 main instance,
// LATENCY=0 second instance).
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_valid0 = 1'b0;
  logic        req_ready, req_ready0;
  logic [31:0] addr = 32'd0, addr0 = 32'd0;
  logic [31:0] wdata = 32'd0, wdata0 = 32'd0;
  logic [1:0]  mem_wr = 2'b00, mem_wr0 = 2'b00;
  logic [2:0]  mem_read = 3'd0, mem_read0 = 3'd0;
  logic        resp_valid, resp_valid0;
  logic [31:0] rdata, rdata0;
  logic        misalign, misalign0;
  logic        busy, busy0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(.ADDR_WIDTH(10), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .addr(addr), .wdata(wdata), .mem_wr(mem_wr), .mem_read(mem_read),
    .resp_valid(resp_valid), .rdata(rdata), .misalign(misalign), .busy(busy)
  );

  dmem_ctrl #(.ADDR_WIDTH(10), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0),
    .addr(addr0), .wdata(wdata0), .mem_wr(mem_wr0), .mem_read(mem_read0),
    .resp_valid(resp_valid0), .rdata(rdata0), .misalign(misalign0), .busy(busy0)
  );

  // Issue one request on the chosen instance; n = edges after the accept edge
  // until resp_valid is seen (40 means no response arrived).
  task automatic do_req(input bit sel, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] wr, input logic [2:0] rd,
                        output int n, output logic [31:0] rdv, output logic mis);
    @(negedge clk);
    if (sel) begin
      addr0 = a; wdata0 = d; mem_wr0 = wr; mem_read0 = rd; req_valid0 = 1'b1;
    end else begin
      addr = a; wdata = d; mem_wr = wr; mem_read = rd; req_valid = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_valid0 = 1'b0;
    n = 0;
    while (!(sel ? resp_valid0 : resp_valid) && n < 40) begin
      @(negedge clk);
      n++;
    end
    rdv = sel ? rdata0 : rdata;
    mis = sel ? misalign0 : misalign;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp got %b exp 0", resp_valid); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rdata); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign got %b exp 0", misalign); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
  endtask

  task automatic test_sw_lw();
    int n; logic [31:0] r; logic m;
    do_req(1'b0, 32'h10, 32'hDEADBEEF, 2'b01, 3'd0, n, r, m);
    checks++; if (n !== 3) begin errors++; $display("FAIL sw_latency got %0d exp 3", n); end
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL sw_rdata got %h exp 0", r); end
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL sw_pulse_end got %b/%b exp 0/1", resp_valid, req_ready); end
    do_req(1'b0, 32'h10, 32'h0, 2'b00, 3'd1, n, r, m);
    checks++; if (n !== 3) begin errors++; $display("FAIL lw_latency got %0d exp 3", n); end
    checks++; if (r !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata got %h exp deadbeef", r); end
    checks++; if (m !== 1'b0) begin errors++; $display("FAIL lw_misalign got %b exp 0", m); end
  endtask

  task automatic test_lanes();
    int n; logic [31:0] r; logic m;
    do_req(1'b0, 32'h20, 32'h0, 2'b01, 3'd0, n, r, m);
    do_req(1'b0, 32'h23, 32'h80, 2'b11, 3'd0, n, r, m);
    do_req(1'b0, 32'h20, 32'h7FFF, 2'b10, 3'd0, n, r, m);
    do_req(1'b0, 32'h20, 32'h0, 2'b00, 3'd1, n, r, m);
    checks++; if (r !== 32'h80007FFF) begin errors++; $display("FAIL lanes_lw got %h exp 80007fff", r); end
    do_req(1'b0, 32'h23, 32'h0, 2'b00, 3'd4, n, r, m);
    checks++; if (r !== 32'hFFFFFF80) begin errors++; $display("FAIL lanes_lb got %h exp ffffff80", r); end
    do_req(1'b0, 32'h23, 32'h0, 2'b00, 3'd5, n, r, m);
    checks++; if (r !== 32'h00000080) begin errors++; $display("FAIL lanes_lbu got %h exp 00000080", r); end
    do_req(1'b0, 32'h22, 32'h0, 2'b00, 3'd2, n, r, m);
    checks++; if (r !== 32'hFFFF8000) begin errors++; $display("FAIL lanes_lh got %h exp ffff8000", r); end
    do_req(1'b0, 32'h20, 32'h0, 2'b00, 3'd3, n, r, m);
    checks++; if (r !== 32'h00007FFF) begin errors++; $display("FAIL lanes_lhu got %h exp 00007fff", r); end
  endtask

  task automatic test_misalign();
    int n; logic [31:0] r; logic m;
    do_req(1'b0, 32'h02, 32'h0, 2'b00, 3'd1, n, r, m);
    checks++; if (n !== 0) begin errors++; $display("FAIL mis_lw_latency got %0d exp 0", n); end
    checks++; if (m !== 1'b1) begin errors++; $display("FAIL mis_lw_flag got %b exp 1", m); end
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL mis_lw_rdata got %h exp 0", r); end
    @(negedge clk);
    checks++; if (misalign !== 1'b0 || resp_valid !== 1'b0) begin errors++; $display("FAIL mis_clear got %b/%b exp 0/0", misalign, resp_valid); end
    do_req(1'b0, 32'h21, 32'h1234, 2'b10, 3'd0, n, r, m);
    checks++; if (m !== 1'b1) begin errors++; $display("FAIL mis_sh_flag got %b exp 1", m); end
    do_req(1'b0, 32'h20, 32'h0, 2'b00, 3'd1, n, r, m);
    checks++; if (r !== 32'h80007FFF) begin errors++; $display("FAIL mis_sh_nowrite got %h exp 80007fff", r); end
    do_req(1'b0, 32'h21, 32'h0, 2'b00, 3'd4, n, r, m);
    checks++; if (m !== 1'b0) begin errors++; $display("FAIL mis_lb_flag got %b exp 0", m); end
    checks++; if (r !== 32'h0000007F) begin errors++; $display("FAIL mis_lb_rdata got %h exp 0000007f", r); end
  endtask

  task automatic test_reset_mid();
    int n; int seen; logic [31:0] r; logic m;
    do_req(1'b0, 32'h40, 32'hAAAAAAAA, 2'b01, 3'd0, n, r, m);
    do_req(1'b0, 32'h40, 32'h0, 2'b00, 3'd1, n, r, m);
    @(negedge clk);
    addr = 32'h40; wdata = 32'h12345678; mem_wr = 2'b01; mem_read = 3'd0; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy got %b exp 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (rdata !== 32'h0 || busy !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_outputs got %h/%b/%b exp 0/0/1", rdata, busy, req_ready); end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rstmid_noresp got %0d exp 0", seen); end
    do_req(1'b0, 32'h40, 32'h0, 2'b00, 3'd1, n, r, m);
    checks++; if (r !== 32'hAAAAAAAA) begin errors++; $display("FAIL rstmid_ram got %h exp aaaaaaaa", r); end
  endtask

  task automatic test_back_to_back();
    int k; int resps; int viol; bit acc; int n; logic [31:0] r; logic m;
    k = 0; resps = 0; viol = 0;
    @(negedge clk);
    addr = 32'h50; wdata = 32'h1; mem_wr = 2'b01; mem_read = 3'd0; req_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      acc = req_ready && req_valid;
      @(posedge clk);
      @(negedge clk);
      if (acc) begin
        k++;
        if (k < 3) begin
          addr = 32'h50 + 32'(4 * k); wdata = 32'(k + 1);
        end else begin
          req_valid = 1'b0;
        end
      end
      if (resp_valid) resps++;
      if (busy === req_ready) viol++;
    end
    checks++; if (k !== 3) begin errors++; $display("FAIL b2b_accepts got %0d exp 3", k); end
    checks++; if (resps !== 3) begin errors++; $display("FAIL b2b_resps got %0d exp 3", resps); end
    checks++; if (viol !== 0) begin errors++; $display("FAIL b2b_ready_busy got %0d exp 0", viol); end
    do_req(1'b0, 32'h54, 32'h0, 2'b00, 3'd1, n, r, m);
    checks++; if (r !== 32'h2) begin errors++; $display("FAIL b2b_data got %h exp 00000002", r); end
    do_req(1'b0, 32'h1000, 32'h11, 2'b01, 3'd0, n, r, m);
    do_req(1'b0, 32'h0, 32'h0, 2'b00, 3'd1, n, r, m);
    checks++; if (r !== 32'h00000011) begin errors++; $display("FAIL wrap got %h exp 00000011", r); end
  endtask

  task automatic test_edges();
    int n; int bz; logic [31:0] r; logic m;
    do_req(1'b1, 32'h8, 32'h5A5A1234, 2'b01, 3'd0, n, r, m);
    checks++; if (n !== 1) begin errors++; $display("FAIL lat0_sw_latency got %0d exp 1", n); end
    do_req(1'b1, 32'h8, 32'h0, 2'b00, 3'd1, n, r, m);
    checks++; if (n !== 1 || r !== 32'h5A5A1234) begin errors++; $display("FAIL lat0_lw got %0d/%h exp 1/5a5a1234", n, r); end
    do_req(1'b0, 32'h60, 32'hCAFEF00D, 2'b01, 3'd1, n, r, m);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL both_rdata got %h exp 0", r); end
    do_req(1'b0, 32'h60, 32'h0, 2'b00, 3'd1, n, r, m);
    checks++; if (r !== 32'hCAFEF00D) begin errors++; $display("FAIL both_write got %h exp cafef00d", r); end
    bz = 0;
    @(negedge clk);
    addr = 32'h60; mem_wr = 2'b00; mem_read = 3'd0; req_valid = 1'b1;
    repeat (3) begin @(negedge clk); if (busy) bz++; end
    mem_read = 3'd6;
    repeat (3) begin @(negedge clk); if (busy || !req_ready) bz++; end
    req_valid = 1'b0;
    checks++; if (bz !== 0) begin errors++; $display("FAIL none_busy got %0d exp 0", bz); end
  endtask

  initial begin
    test_reset();
    test_sw_lw();
    test_lanes();
    test_misalign();
    test_reset_mid();
    test_back_to_back();
    test_edges();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
